// File: rtl/serial_servo_cmd_decoder.sv
// -----------------------------------------------------------------------------
// serial_servo_cmd_decoder
//
// Turns ASCII characters from the UART receiver into servo position commands.
// For every complete command it sends a one-character reply to the UART
// transmitter.
//
// Command set:
//   'P' <d>  Set the servo position to digit d ('0'..'7'). Reply 'K'. If the
//            argument is bad, has bad parity or never arrives, reply 'E'.
//   '?'      Report the position as the digit '0' + posicao.
//   other    Reply 'E'. A character with bad parity also gets 'E'.
//
// Optional build macro:
//   SERVO_CMD_LOWERCASE_EN  When defined, 'p' is accepted as a synonym for 'P'.
//
// Ports:
//   clock         system clock
//   reset         asynchronous reset, active-low
//   rx_valid      one-cycle strobe: rx_data/rx_parity_ok carry a new character
//   rx_data       received character (N_BITS)
//   rx_parity_ok  parity result that goes with rx_data
//   tx_done       one-cycle strobe: the transmitter finished the reply
//   tx_start      one-cycle request to transmit tx_data
//   tx_data       reply character, held from tx_start until tx_done
//   posicao       current servo position index (0..7)
//   pos_valid     one-cycle strobe in the first cycle a new posicao is shown
//   erro          1 if the last completed command failed
//   db_estado     FSM state code for the debug display
// -----------------------------------------------------------------------------
module serial_servo_cmd_decoder #(
    parameter int N_BITS         = 7,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int POS_RESET      = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [N_BITS-1:0] rx_data,
    input  logic              rx_parity_ok,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [N_BITS-1:0] tx_data,
    output logic [2:0]        posicao,
    output logic              pos_valid,
    output logic              erro,
    output logic [3:0]        db_estado
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [N_BITS-1:0] CH_P     = N_BITS'(8'h50);
    localparam logic [N_BITS-1:0] CH_P_LC  = N_BITS'(8'h70);
    localparam logic [N_BITS-1:0] CH_QUERY = N_BITS'(8'h3F);
    localparam logic [N_BITS-1:0] CH_0     = N_BITS'(8'h30);
    localparam logic [N_BITS-1:0] CH_7     = N_BITS'(8'h37);
    localparam logic [N_BITS-1:0] CH_ACK   = N_BITS'(8'h4B);
    localparam logic [N_BITS-1:0] CH_ERR   = N_BITS'(8'h45);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_ARG   = 4'd1,
        ST_APPLY      = 4'd2,
        ST_REPLY_SEND = 4'd3,
        ST_REPLY_WAIT = 4'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        pos_q, pos_d;
    logic [N_BITS-1:0] reply_q, reply_d;
    logic              erro_q, erro_d;

    // Values for the single reply-loading path shared by all states.
    logic              reply_load;
    logic              reply_err;
    logic [N_BITS-1:0] reply_char;

    logic is_cmd_p;
    logic is_digit;

    always_comb begin
        is_cmd_p = (rx_data == CH_P);
`ifdef SERVO_CMD_LOWERCASE_EN
        if (rx_data == CH_P_LC) begin
            is_cmd_p = 1'b1;
        end
`endif
        is_digit = (rx_data >= CH_0) && (rx_data <= CH_7);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        reply_d    = reply_q;
        erro_d     = erro_q;
        reply_load = 1'b0;
        reply_err  = 1'b1;
        reply_char = CH_ERR;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (!rx_parity_ok) begin
                        reply_load = 1'b1;
                    end else if (is_cmd_p) begin
                        state_d = ST_WAIT_ARG;
                        cnt_d   = '0;
                    end else if (rx_data == CH_QUERY) begin
                        reply_load = 1'b1;
                        reply_err  = 1'b0;
                        reply_char = N_BITS'(32'h30 + 32'(pos_q));
                    end else begin
                        reply_load = 1'b1;
                    end
                end
            end

            ST_WAIT_ARG: begin
                // A character that arrives in the expiry cycle beats the timeout.
                if (rx_valid) begin
                    if (rx_parity_ok && is_digit) begin
                        // Latch the argument now. rx_data is gone by the
                        // next cycle. APPLY then marks the change with
                        // pos_valid.
                        state_d = ST_APPLY;
                        pos_d   = rx_data[2:0];
                    end else begin
                        reply_load = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    reply_load = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_APPLY: begin
                reply_load = 1'b1;
                reply_err  = 1'b0;
                reply_char = CH_ACK;
            end

            ST_REPLY_SEND: begin
                state_d = ST_REPLY_WAIT;
            end

            ST_REPLY_WAIT: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reply_load) begin
            state_d = ST_REPLY_SEND;
            reply_d = reply_char;
            erro_d  = reply_err;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pos_q   <= 3'(POS_RESET);
            reply_q <= '0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            reply_q <= reply_d;
            erro_q  <= erro_d;
        end
    end

    // These are decoded from the state register, so an asynchronous reset
    // drops tx_start at once.
    assign tx_start  = (state_q == ST_REPLY_SEND);
    assign pos_valid = (state_q == ST_APPLY);
    assign tx_data   = reply_q;
    assign posicao   = pos_q;
    assign erro      = erro_q;
    assign db_estado = state_q;

endmodule

// File: doc/serial_servo_cmd_decoder.md
Name: serial_servo_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver and upstream of the servo PWM generator and UART transmitter in the serial servo test system.
- Parses received ASCII characters into servo position commands and drives the servo position.
- Queues a one-character reply (ack, error or position report) to the transmitter for every complete command.

Parameters:
- N_BITS, 7, character width; must match the receiver and transmitter.
- TIMEOUT_CYCLES, 100_000_000, clock cycles allowed between command character and argument (2 s at 50 MHz).
- POS_RESET, 0, servo position loaded at reset (0..7).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-low; clears all state.
- rx_valid  in  1  one-cycle pulse: a new character is present on rx_data (receiver end-of-reception strobe).
- rx_data  in  N_BITS  received character; valid only in the rx_valid cycle.
- rx_parity_ok  in  1  parity check result for rx_data; sampled with rx_valid.
- tx_done  in  1  one-cycle pulse from the transmitter when a character has finished sending.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  out  N_BITS  reply character; held stable from the tx_start cycle until tx_done.
- posicao  out  3  current servo position index; feeds the PWM generator.
- pos_valid  out  1  one-cycle pulse in the cycle posicao changes.
- erro  out  1  high if the last completed command failed; held until the next command completes.
- db_estado  out  4  current FSM state encoding, for the hex display.

Behaviour:
- Reset values (reset low, asynchronous):
  - posicao = POS_RESET; tx_start = 0; tx_data = 0; pos_valid = 0; erro = 0.
  - FSM in IDLE; timeout counter = 0.
- Character codes:
  - 'P' = 0x50, '?' = 0x3F.
  - Digits '0'..'7' = 0x30..0x37.
  - Replies: 'K' = 0x4B (ack), 'E' = 0x45 (error).
- FSM states and transitions (db_estado encoding in brackets):
  - IDLE [0]: on rx_valid:
    - rx_parity_ok = 0 → reply 'E'.
    - 'P' → WAIT_ARG, timeout counter cleared.
    - '?' → reply ('0' + posicao).
    - any other character → reply 'E'.
  - WAIT_ARG [1]:
    - Counter increments every cycle; reaching TIMEOUT_CYCLES-1 without rx_valid → reply 'E'.
    - On rx_valid with good parity and a digit 0x30..0x37 → APPLY.
    - On rx_valid with bad parity or a non-digit → reply 'E'; posicao unchanged.
  - APPLY [2]: one cycle; posicao <= rx_data[2:0]; pos_valid = 1; then reply 'K'.
  - REPLY_SEND [3]: tx_data loaded on entry; tx_start high exactly one cycle; then → REPLY_WAIT.
  - REPLY_WAIT [4]: waits for tx_done; then → IDLE.
- erro update:
  - Set to 1 when entering REPLY_SEND with 'E'.
  - Cleared to 0 with 'K' or a position report.
- Latency:
  - Argument rx_valid → posicao update: 1 cycle (APPLY register).
  - Argument rx_valid → tx_start: 2 cycles.
  - rx_valid in IDLE → tx_start for '?' or error: 1 cycle.
- Boundaries:
  - rx_valid during REPLY_SEND or REPLY_WAIT: character dropped; no state change; posicao unchanged.
  - tx_done outside REPLY_WAIT: ignored.
  - Simultaneous rx_valid and timeout expiry in WAIT_ARG: rx_valid wins.
  - Reset mid-reply: tx_start forced low immediately; FSM → IDLE.
  - Command 'P' directly followed by 'P': second 'P' is a non-digit → 'E'.
  - Unused state codes → IDLE on next clock.
- Timeout counter width: $clog2(TIMEOUT_CYCLES); counter saturates, never wraps.

Optional Feature:
- SERVO_CMD_LOWERCASE_EN:
  - Defined: 'p' (0x70) is accepted identically to 'P' in IDLE.
  - Undefined: 'p' is an unknown character → reply 'E'.
- All other behaviour is identical either way.

Test Plan:
- Reset low, then high → posicao = 0, erro = 0, db_estado = 0, tx_start = 0.
- rx 0x50 then 0x35, good parity → pos_valid pulse, posicao = 5, tx_start with tx_data = 0x4B; after tx_done, db_estado = 0.
- With posicao = 5, rx 0x3F → tx_data = 0x35, erro = 0.
- rx 0x50 then 0x39 → tx_data = 0x45, erro = 1, posicao unchanged at 5.
- rx 0x50, no further input, TIMEOUT_CYCLES = 100 → reply 0x45 after 100 cycles.
- rx 0x50 with rx_parity_ok = 0 → reply 0x45, FSM never enters WAIT_ARG.
- During REPLY_WAIT, inject rx 0x3F → dropped, exactly one tx_start observed.
